// File: rtl/pix_scramble_tx_if.sv
// Pixel-port bundle: upstream byte handshake plus the consumer request/pixel pins.
interface pix_scramble_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              pix_req;
    logic [DATA_W-1:0] pixel_in;
    logic              pix_valid;

    modport master (
        output s_data, s_valid, pix_req,
        input  s_ready, pixel_in, pix_valid
    );

    modport slave (
        input  s_data, s_valid, pix_req,
        output s_ready, pixel_in, pix_valid
    );
endinterface

// File: rtl/pix_scramble_tx.sv
// Transmit-side pixel source: buffers upstream bytes in a FIFO and answers each
// consumer pix_req with one KEY-scrambled pixel, tracking underruns and delivery count.
module pix_scramble_tx #(
    parameter int         DEPTH     = 8,
    parameter int         AW        = 3,
    parameter logic [7:0] KEY       = 8'hCC,
    parameter int         START_LVL = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    en,
    input  logic                    flush,
    input  logic                    clr_underrun,
    pix_scramble_tx_if.slave        bus,
    output logic                    underrun,
    output logic [AW:0]             level,
    output logic [15:0]             tx_count
);
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       wr_ptr;
    logic                full;
    logic                empty;
    logic                push;
    logic                serve;
    logic                pop;
    logic                starve;
    logic [DATA_W-1:0]   pixel_p1;
    logic                vld_p1;

    function automatic logic [DATA_W-1:0] scramble(input logic [DATA_W-1:0] d);
        return d ^ KEY;
    endfunction

    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);

    // s_ready deliberately ignores pix_req: a full FIFO refuses a push even while popping.
    assign bus.s_ready = en && !full;
    assign push        = bus.s_valid && en && !full && !flush;
    assign serve       = en && (state == RUN) && bus.pix_req && !flush;
    assign pop         = serve && !empty;
    assign starve      = serve && empty;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.s_data;
    end

    // Stage p1: popped head scrambled into the registered pixel output.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            pixel_p1 <= '0;
            vld_p1   <= 1'b0;
            underrun <= 1'b0;
            tx_count <= '0;
        end else begin
            vld_p1 <= pop;
            if (pop) begin
                pixel_p1 <= scramble(mem[rd_ptr]);
                tx_count <= tx_count + 16'd1;
            end

            if (starve)
                underrun <= 1'b1;
            else if (clr_underrun)
                underrun <= 1'b0;

            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                level  <= '0;
                state  <= en ? FILL : IDLE;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: ;
                endcase

                if (!en) begin
                    state <= IDLE;
                end else begin
                    case (state)
                        IDLE:    state <= FILL;
                        FILL:    if (level >= (AW+1)'(START_LVL)) state <= RUN;
                        RUN:     if (starve) state <= FILL;
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    assign bus.pixel_in  = pixel_p1;
    assign bus.pix_valid = vld_p1;
endmodule

// File: doc/pix_scramble_tx.md
Name: pix_scramble_tx

Overview:
- Transmit-side pixel source for the pixel port of the DSP front end.
- Buffers upstream bytes in a small FIFO and answers the consumer's pix_req strobes with one pixel per request.
- Pre-scrambles each byte with KEY. The consumer XORs with the same KEY (8'hCC), so pixel_out at the consumer equals the original upstream byte.
- Sits between the upstream pixel producer and the consumer's pixel_in/pix_req pins.

Parameters:
- DEPTH, 8, FIFO depth in bytes; power of 2, minimum 2.
- AW, 3, log2(DEPTH).
- KEY, 8'hCC, XOR scramble key; must match the consumer.
- START_LVL, 4, FIFO level required before serving starts (FILL to RUN); range 1..DEPTH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  asynchronous, active-high reset; clock clk.
- en  in  1  block enable.
- flush  in  1  synchronous FIFO clear, single-cycle pulse.
- s_data  in  8  upstream pixel byte.
- s_valid  in  1  upstream data valid.
- s_ready  out  1  upstream ready.
- pix_req  in  1  consumer pixel request, one request per high cycle.
- pixel_in  out  8  scrambled pixel to consumer (registered).
- pix_valid  out  1  one-cycle pulse; pixel_in updated this cycle.
- underrun  out  1  sticky underrun flag.
- clr_underrun  in  1  clears underrun.
- level  out  AW+1  current FIFO occupancy, 0..DEPTH.
- tx_count  out  16  pixels delivered; wraps 16'hFFFF to 0.

Behaviour:
- Reset (rstn=1, asynchronous):
  - FIFO empty, level=0, state=IDLE.
  - pixel_in=8'h00, pix_valid=0, underrun=0, tx_count=0.
  - Reset mid-transfer discards FIFO contents; no partial pixel is presented.
- States:
  - IDLE: entered when en=0 from any state. FIFO contents are held, s_ready=0, pix_req ignored (no pop, no underrun).
  - IDLE to FILL when en=1.
  - FILL: pushes allowed; pix_req ignored. FILL to RUN when level >= START_LVL, evaluated on the registered level.
  - RUN: serves requests. RUN to FILL on an underrun.
- Upstream handshake:
  - s_ready = en and not full, combinational; never depends on pix_req.
  - A push occurs when s_valid and s_ready are both high at a rising edge.
  - Full with a simultaneous pop: s_ready stays 0 that cycle (no bypass).
- Pop, RUN and pix_req=1:
  - Not empty: head is popped; at the same edge pixel_in <= head ^ KEY, pix_valid <= 1, tx_count increments.
  - Latency: pix_req sampled at edge N, so pixel_in/pix_valid are valid after edge N, one cycle.
  - Empty: no pop; pixel_in holds its last value, pix_valid=0, underrun <= 1, state goes to FILL.
  - A push in the same cycle as an empty pop does not bypass; it still counts as underrun.
- pix_valid is 0 in every cycle without a successful pop.
- Simultaneous push and pop: both occur, level unchanged.
- Pointers: read/write pointers are AW bits and wrap modulo DEPTH. Full/empty are derived from level.
- flush:
  - Pointers and level go to 0; state goes to FILL if en=1, else IDLE.
  - flush overrides a push or pop in the same cycle.
  - pixel_in, underrun and tx_count are unaffected.
- underrun: clr_underrun clears it. Set wins over clear in the same cycle.
- tx_count is 16-bit unsigned and wraps silently.

Test Plan:
- Scramble round trip: push 8'h00, 8'hFF, 8'h33, 8'hCC with en=1, then pix_req for 4 cycles -> pixel_in sequence 8'hCC, 8'h33, 8'hFF, 8'h00, each with pix_valid=1 one cycle after the request; tx_count=4.
- Start threshold: push 3 bytes (START_LVL=4), assert pix_req -> no pix_valid, underrun=0; push a 4th byte, pix_req -> first byte ^ 8'hCC delivered.
- Full and concurrent push/pop: push 8 bytes -> level=8, s_ready=0; hold s_valid with pix_req for 1 cycle -> one pop, no push, level=7; next cycle push+pop -> level stays 7.
- Underrun: in RUN drain to empty, pix_req again -> pix_valid=0, pixel_in holds last value, underrun=1, state FILL; clr_underrun=1 -> underrun=0 next cycle; set and clear in the same cycle -> underrun stays 1.
- Flush and enable: level=5, flush with s_valid=1 -> level=0, byte not stored; en=0 with level=3 -> s_ready=0, pix_req ignored, level stays 3; en=1 -> FILL.
- Async reset mid-stream: assert rstn between clock edges during RUN -> outputs go immediately to reset values (pix_valid=0, level=0, tx_count=0); after release, normal fill/serve resumes.
